// File: rtl/tick_timer_sched_if.sv
// Configuration and event port bundle for tick_timer_sched.
// master: software/consumer side, slave: the timer block.
interface tick_timer_sched_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic             cfg_start;
    logic             cfg_periodic;
    logic [CNT_W-1:0] cfg_period;
    logic             tick;
    logic [NCH-1:0]   busy;
    logic [NCH-1:0]   overrun;
    logic             evt_valid;
    logic [CH_W-1:0]  evt_ch;
    logic             evt_ready;

    modport master (
        output cfg_we, cfg_ch, cfg_start, cfg_periodic, cfg_period, evt_ready,
        input  tick, busy, overrun, evt_valid, evt_ch
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_start, cfg_periodic, cfg_period, evt_ready,
        output tick, busy, overrun, evt_valid, evt_ch
    );
endinterface

// File: rtl/tick_timer_sched.sv
// Shared tick prescaler feeding NCH one-shot/periodic timer channels whose
// expiry events are arbitrated round-robin onto one valid/ready port.
// Optional build macro SQUARE_OUT_EN adds sq_out, toggling on every tick.
//
// Channel states:
//   state | meaning
//   IDLE  | channel stopped, count frozen
//   RUN   | channel counts down one per tick, expires when count is 1
module tick_timer_sched #(
    parameter int TICK_DIV = 50000,
    parameter int NCH      = 4,
    parameter int CNT_W    = 16,
    parameter int CH_W     = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef SQUARE_OUT_EN
    output logic sq_out,
`endif
    tick_timer_sched_if.slave bus
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_e;

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             tick_q, tick_d;
    ch_state_e        state_q [NCH];
    ch_state_e        state_d [NCH];
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CNT_W-1:0] period_q [NCH];
    logic [CNT_W-1:0] period_d [NCH];
    logic [NCH-1:0]   periodic_q, periodic_d;
    logic [NCH-1:0]   pend_q, pend_d;
    logic [NCH-1:0]   ovr_q, ovr_d;
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]  rr_q, rr_d;
    logic             xfer;
    logic [NCH-1:0]   accept;
    logic [NCH-1:0]   cand;
    logic [NCH-1:0]   busy_w;

    // Prescaler wrap and registered tick strobe.
    always_comb begin
        tick_d    = (pre_cnt_q == PRE_W'(TICK_DIV - 1));
        pre_cnt_d = tick_d ? '0 : pre_cnt_q + 1'b1;
    end

    // Which channel (if any) hands its event to the consumer this cycle.
    always_comb begin
        xfer = evt_valid_q && bus.evt_ready;
        for (int i = 0; i < NCH; i++) begin
            accept[i] = xfer && (evt_ch_q == CH_W'(i));
        end
    end

    // Channel next state: a cfg write to a channel overrides its tick.
    always_comb begin
        logic cfg_hit;
        cfg_hit    = 1'b0;
        periodic_d = periodic_q;
        pend_d     = pend_q & ~accept;
        ovr_d      = ovr_q;
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            period_d[i] = period_q[i];
            cfg_hit     = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
            if (cfg_hit && bus.cfg_start && (bus.cfg_period != '0)) begin
                state_d[i]    = RUN;
                cnt_d[i]      = bus.cfg_period;
                period_d[i]   = bus.cfg_period;
                periodic_d[i] = bus.cfg_periodic;
                ovr_d[i]      = 1'b0;
            end else if (cfg_hit && !bus.cfg_start) begin
                state_d[i] = IDLE;
                ovr_d[i]   = 1'b0;
            end else if (tick_q && (state_q[i] == RUN)) begin
                if (cnt_q[i] == CNT_W'(1)) begin
                    pend_d[i] = 1'b1;
                    // Events do not queue; a still-pending one is an overrun.
                    if (pend_q[i] && !accept[i]) begin
                        ovr_d[i] = 1'b1;
                    end
                    if (periodic_q[i]) begin
                        cnt_d[i] = period_q[i];
                    end else begin
                        state_d[i] = IDLE;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Round-robin pick from the pointer upward; presented event held until taken.
    always_comb begin
        int idx;
        idx         = 0;
        rr_d        = rr_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        cand        = pend_q & ~accept;
        if (xfer) begin
            rr_d = (evt_ch_q == CH_W'(NCH - 1)) ? '0 : evt_ch_q + 1'b1;
        end
        if (!evt_valid_q || xfer) begin
            evt_valid_d = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                idx = (int'(rr_d) + k) % NCH;
                if (!evt_valid_d && cand[idx]) begin
                    evt_valid_d = 1'b1;
                    evt_ch_d    = CH_W'(idx);
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt_q   <= '0;
            tick_q      <= 1'b0;
            periodic_q  <= '0;
            pend_q      <= '0;
            ovr_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_q        <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= IDLE;
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            tick_q      <= tick_d;
            periodic_q  <= periodic_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            rr_q        <= rr_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                cnt_q[i]    <= cnt_d[i];
                period_q[i] <= period_d[i];
            end
        end
    end

`ifdef SQUARE_OUT_EN
    logic sq_q;

    // Square wave: one half-period per tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sq_q <= 1'b0;
        end else if (tick_q) begin
            sq_q <= ~sq_q;
        end
    end

    assign sq_out = sq_q;
`endif

    // Busy flags decoded from channel states.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy_w[i] = (state_q[i] == RUN);
        end
    end

    assign bus.tick      = tick_q;
    assign bus.busy      = busy_w;
    assign bus.overrun   = ovr_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_ch    = evt_ch_q;

endmodule

// File: tb/tb_tick_timer_sched.sv
// Directed bench for tick_timer_sched with TICK_DIV=10; cyc counts clk edges
// since reset release, outputs sampled 1 time unit after each rising edge.
module tb_tick_timer_sched;
    localparam int TICK_DIV = 10;
    localparam int NCH      = 4;
    localparam int CNT_W    = 16;
    localparam int CH_W     = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
`ifdef SQUARE_OUT_EN
    logic sq_out;
`endif

    tick_timer_sched_if #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) bus ();

    tick_timer_sched #(
        .TICK_DIV(TICK_DIV),
        .NCH     (NCH),
        .CNT_W   (CNT_W),
        .CH_W    (CH_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SQUARE_OUT_EN
        .sq_out(sq_out),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic cfg_write(input int ch, input logic start, input logic periodic, input int period);
        bus.cfg_we       = 1'b1;
        bus.cfg_ch       = CH_W'(ch);
        bus.cfg_start    = start;
        bus.cfg_periodic = periodic;
        bus.cfg_period   = CNT_W'(period);
        step();
        bus.cfg_we       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order [4];
        order = '{2, 3, 0, 1};

        rst_n            = 1'b0;
        bus.cfg_we       = 1'b0;
        bus.cfg_ch       = '0;
        bus.cfg_start    = 1'b0;
        bus.cfg_periodic = 1'b0;
        bus.cfg_period   = '0;
        bus.evt_ready    = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        cyc   = 0;

        check_val("rst_tick", 32'(bus.tick), 0);
        check_val("rst_busy", 32'(bus.busy), 0);
        check_val("rst_ovr", 32'(bus.overrun), 0);
        check_val("rst_valid", 32'(bus.evt_valid), 0);
        check_val("rst_ch", 32'(bus.evt_ch), 0);

        // Prescaler only: ticks at 10, 20, 30.
        for (int n = 1; n <= 35; n++) begin
            step();
            check_val("tick_period", 32'(bus.tick), 32'(cyc % 10 == 0));
        end
        check_val("idle_busy", 32'(bus.busy), 0);
        check_val("idle_valid", 32'(bus.evt_valid), 0);

        // ch0 one-shot period 3: ticks 40, 50, 60 -> expires at edge 61.
        bus.evt_ready = 1'b1;
        cfg_write(0, 1'b1, 1'b0, 3);
        check_val("os_busy_start", 32'(bus.busy), 32'h1);
        run_to(60);
        check_val("os_tick60", 32'(bus.tick), 1);
        check_val("os_busy_60", 32'(bus.busy), 32'h1);
        step();
        check_val("os_busy_exp", 32'(bus.busy), 0);
        check_val("os_valid_61", 32'(bus.evt_valid), 0);
        step();
        check_val("os_valid_62", 32'(bus.evt_valid), 1);
        check_val("os_ch_62", 32'(bus.evt_ch), 0);
        step();
        check_val("os_valid_63", 32'(bus.evt_valid), 0);
        run_to(85);
        check_val("os_no_more", 32'(bus.evt_valid), 0);

        // ch1 periodic period 2, consumer stalled: expiries at 101, 121, 141.
        bus.evt_ready = 1'b0;
        cfg_write(1, 1'b1, 1'b1, 2);
        check_val("per_busy", 32'(bus.busy), 32'h2);
        run_to(101);
        check_val("per_valid_101", 32'(bus.evt_valid), 0);
        step();
        check_val("per_valid_102", 32'(bus.evt_valid), 1);
        check_val("per_ch_102", 32'(bus.evt_ch), 1);
        run_to(120);
        check_val("per_hold_valid", 32'(bus.evt_valid), 1);
        check_val("per_hold_ch", 32'(bus.evt_ch), 1);
        check_val("per_ovr_120", 32'(bus.overrun), 0);
        step();
        check_val("per_ovr_121", 32'(bus.overrun), 32'h2);
        run_to(141);
        check_val("per_ovr_141", 32'(bus.overrun), 32'h2);
        check_val("per_valid_141", 32'(bus.evt_valid), 1);
        check_val("per_busy_141", 32'(bus.busy), 32'h2);
        run_to(145);
        cfg_write(1, 1'b0, 1'b0, 0);
        check_val("stop_busy", 32'(bus.busy), 0);
        check_val("stop_ovr", 32'(bus.overrun), 0);
        check_val("stop_valid", 32'(bus.evt_valid), 1);
        run_to(150);
        check_val("stop_ch_150", 32'(bus.evt_ch), 1);
        bus.evt_ready = 1'b1;
        step();
        check_val("stop_taken", 32'(bus.evt_valid), 0);

        // All channels period 1 periodic; RR pointer sits at 2 after ch1.
        run_to(152);
        for (int c = 0; c < 4; c++) cfg_write(c, 1'b1, 1'b1, 1);
        check_val("all_busy", 32'(bus.busy), 32'hF);
        run_to(161);
        check_val("all_valid_161", 32'(bus.evt_valid), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("rr1_valid", 32'(bus.evt_valid), 1);
            check_val("rr1_ch", 32'(bus.evt_ch), 32'(order[k]));
        end
        step();
        check_val("rr1_done", 32'(bus.evt_valid), 0);
        run_to(171);
        check_val("rr_no_ovr", 32'(bus.overrun), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("rr2_ch", 32'(bus.evt_ch), 32'(order[k]));
        end
        for (int c = 0; c < 4; c++) cfg_write(c, 1'b0, 1'b0, 0);
        check_val("rr_all_stopped", 32'(bus.busy), 0);
        check_val("rr2_done", 32'(bus.evt_valid), 0);

        // cfg write to ch2 in the tick cycle: full count of 5 -> expiry at 231.
        run_to(180);
        check_val("coinc_tick", 32'(bus.tick), 1);
        cfg_write(2, 1'b1, 1'b0, 5);
        check_val("coinc_busy", 32'(bus.busy), 32'h4);
        cfg_write(3, 1'b1, 1'b0, 9);
        cfg_write(3, 1'b1, 1'b0, 0);
        check_val("zero_per_busy", 32'(bus.busy), 32'hC);
        run_to(230);
        check_val("coinc_busy_230", 32'(bus.busy), 32'hC);
        step();
        check_val("coinc_busy_231", 32'(bus.busy), 32'h8);
        step();
        check_val("coinc_valid", 32'(bus.evt_valid), 1);
        check_val("coinc_ch", 32'(bus.evt_ch), 2);
        step();
        check_val("coinc_taken", 32'(bus.evt_valid), 0);
        run_to(270);
        check_val("ch3_busy_270", 32'(bus.busy), 32'h8);
        step();
        check_val("ch3_busy_271", 32'(bus.busy), 0);
        step();
        check_val("ch3_valid", 32'(bus.evt_valid), 1);
        check_val("ch3_ch", 32'(bus.evt_ch), 3);
        step();
        check_val("ch3_taken", 32'(bus.evt_valid), 0);

        // Reset with two events pending.
        bus.evt_ready = 1'b0;
        cfg_write(0, 1'b1, 1'b0, 1);
        cfg_write(1, 1'b1, 1'b0, 1);
        run_to(282);
        check_val("pre_rst_valid", 32'(bus.evt_valid), 1);
        check_val("pre_rst_ch", 32'(bus.evt_ch), 0);
        rst_n = 1'b0;
        step();
        check_val("mid_rst_valid", 32'(bus.evt_valid), 0);
        check_val("mid_rst_busy", 32'(bus.busy), 0);
        check_val("mid_rst_ovr", 32'(bus.overrun), 0);
        check_val("mid_rst_tick", 32'(bus.tick), 0);
        check_val("mid_rst_ch", 32'(bus.evt_ch), 0);
        rst_n = 1'b1;
        cyc   = 0;
`ifdef SQUARE_OUT_EN
        check_val("sq_rst", 32'(sq_out), 0);
`endif
        bus.evt_ready = 1'b1;
        for (int n = 1; n <= 21; n++) begin
            step();
            check_val("post_rst_tick", 32'(bus.tick), 32'(cyc % 10 == 0));
`ifdef SQUARE_OUT_EN
            check_val("sq_wave", 32'(sq_out), 32'((cyc >= 11) ^ (cyc >= 21)));
`endif
        end
        check_val("post_rst_valid", 32'(bus.evt_valid), 0);
        check_val("post_rst_busy", 32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
